mandelbrot_pixel_scheduler: RTL

MANDELBROT_PIXEL_SCHEDULER -- requirements
Module: mandelbrot_pixel_scheduler

---
 rtl/mandelbrot_pixel_scheduler_if.sv | 58 +++++
 rtl/mandelbrot_pixel_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_pixel_scheduler_if.sv
// Purpose: frame command, iteration-core and pixel-stream signals of the Mandelbrot pixel scheduler.
// Ports: master modport = scheduler side (drives *_o), slave modport = environment side (drives *_i).
// Suffixes are named from the scheduler's point of view; pix_* is a valid/ready stream.
interface mandelbrot_pixel_scheduler_if #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int MAX_ITER_WIDTH  = 16,
    parameter int COORD_WIDTH     = 12
);
    localparam int DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS;

    // frame command
    logic                          frame_start_i;
    logic        [COORD_WIDTH-1:0] width_i;
    logic        [COORD_WIDTH-1:0] height_i;
    logic signed [DATA_WIDTH-1:0]  x_origin_i;
    logic signed [DATA_WIDTH-1:0]  y_origin_i;
    logic signed [DATA_WIDTH-1:0]  step_i;
    logic     [MAX_ITER_WIDTH-1:0] max_iter_i;

    // iteration core
    logic                          core_start_o;
    logic signed [DATA_WIDTH-1:0]  core_x0_o;
    logic signed [DATA_WIDTH-1:0]  core_y0_o;
    logic     [MAX_ITER_WIDTH-1:0] core_max_iter_o;
    logic     [MAX_ITER_WIDTH-1:0] core_iter_i;
    logic                          core_done_i;

    // pixel stream
    logic                          pix_valid_o;
    logic                          pix_ready_i;
    logic     [MAX_ITER_WIDTH-1:0] pix_iter_o;
    logic        [COORD_WIDTH-1:0] pix_x_o;
    logic        [COORD_WIDTH-1:0] pix_y_o;
    logic                          pix_last_o;

    // status
    logic                          busy_o;
    logic                          frame_done_o;

    modport master (
        input  frame_start_i, width_i, height_i, x_origin_i, y_origin_i, step_i, max_iter_i,
        output core_start_o, core_x0_o, core_y0_o, core_max_iter_o,
        input  core_iter_i, core_done_i,
        output pix_valid_o, pix_iter_o, pix_x_o, pix_y_o, pix_last_o,
        input  pix_ready_i,
        output busy_o, frame_done_o
    );

    modport slave (
        output frame_start_i, width_i, height_i, x_origin_i, y_origin_i, step_i, max_iter_i,
        input  core_start_o, core_x0_o, core_y0_o, core_max_iter_o,
        output core_iter_i, core_done_i,
        input  pix_valid_o, pix_iter_o, pix_x_o, pix_y_o, pix_last_o,
        output pix_ready_i,
        input  busy_o, frame_done_o
    );
endinterface

// File: rtl/mandelbrot_pixel_scheduler.sv
// Purpose: walks a frame in raster order, hands each pixel's c to an iteration core, streams results.
// Latency: frame start -> core_start 1 cycle; pixel handshake -> next core_start 1 cycle.
// Backpressure: pix_valid_o and all pix_* hold until pix_ready_i; no new core work is issued meanwhile.
// Ports: clk_i, rst_ni (async active-low) plus the master modport of mandelbrot_pixel_scheduler_if.
module mandelbrot_pixel_scheduler #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int MAX_ITER_WIDTH  = 16,
    parameter int COORD_WIDTH     = 12
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    mandelbrot_pixel_scheduler_if.master bus
);
    localparam int DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS;
    localparam logic [COORD_WIDTH-1:0] COORD_ONE = COORD_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                      state_q,       state_d;
    logic      [COORD_WIDTH-1:0] width_q,       width_d;
    logic      [COORD_WIDTH-1:0] height_q,      height_d;
    logic      [COORD_WIDTH-1:0] px_q,          px_d;
    logic      [COORD_WIDTH-1:0] py_q,          py_d;
    logic signed [DATA_WIDTH-1:0] x_origin_q,   x_origin_d;
    logic signed [DATA_WIDTH-1:0] step_q,       step_d;
    logic signed [DATA_WIDTH-1:0] cx_q,         cx_d;
    logic signed [DATA_WIDTH-1:0] cy_q,         cy_d;
    logic   [MAX_ITER_WIDTH-1:0] max_iter_q,    max_iter_d;
    logic   [MAX_ITER_WIDTH-1:0] pix_iter_q,    pix_iter_d;
    logic                        pix_last_q,    pix_last_d;
    logic                        pix_valid_q,   pix_valid_d;
    logic                        core_start_q,  core_start_d;
    logic                        busy_q,        busy_d;
    logic                        frame_done_q,  frame_done_d;

    logic      [COORD_WIDTH-1:0] width_m1;
    logic      [COORD_WIDTH-1:0] height_m1;
    logic                        row_end;
    logic                        last_pix;

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        px_d         = px_q;
        py_d         = py_q;
        x_origin_d   = x_origin_q;
        step_d       = step_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        max_iter_d   = max_iter_q;
        pix_iter_d   = pix_iter_q;
        pix_last_d   = pix_last_q;
        frame_done_d = 1'b0;

        width_m1  = width_q - COORD_ONE;
        height_m1 = height_q - COORD_ONE;
        row_end   = (px_q == width_m1);
        last_pix  = row_end && (py_q == height_m1);

        case (state_q)
            S_IDLE: begin
                if (bus.frame_start_i) begin
                    if ((bus.width_i != '0) && (bus.height_i != '0)) begin
                        width_d    = bus.width_i;
                        height_d   = bus.height_i;
                        x_origin_d = bus.x_origin_i;
                        step_d     = bus.step_i;
                        max_iter_d = bus.max_iter_i;
                        px_d       = '0;
                        py_d       = '0;
                        cx_d       = bus.x_origin_i;
                        // y origin is only ever needed as the seed of cy
                        cy_d       = bus.y_origin_i;
                        state_d    = S_ISSUE;
                    end else begin
                        // empty frame: nothing to render, just report completion
                        frame_done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done_i) begin
                    pix_iter_d = bus.core_iter_i;
                    // px/py are frozen until the handshake, so last can be decided here
                    pix_last_d = last_pix;
                    state_d    = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (bus.pix_ready_i) begin
                    if (pix_last_q) begin
                        pix_last_d   = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        if (row_end) begin
                            px_d = '0;
                            cx_d = x_origin_q;
                            py_d = py_q + COORD_ONE;
                            cy_d = cy_q + step_q;
                        end else begin
                            px_d = px_q + COORD_ONE;
                            cx_d = cx_q + step_q;
                        end
                        state_d = S_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // strobes and status are registered off the next state so they line up with it
        core_start_d = (state_d == S_ISSUE);
        pix_valid_d  = (state_d == S_OUTPUT);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            px_q         <= '0;
            py_q         <= '0;
            x_origin_q   <= '0;
            step_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            max_iter_q   <= '0;
            pix_iter_q   <= '0;
            pix_last_q   <= 1'b0;
            pix_valid_q  <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            px_q         <= px_d;
            py_q         <= py_d;
            x_origin_q   <= x_origin_d;
            step_q       <= step_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            max_iter_q   <= max_iter_d;
            pix_iter_q   <= pix_iter_d;
            pix_last_q   <= pix_last_d;
            pix_valid_q  <= pix_valid_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // c and the limit come straight from the accumulators: they only move on a
    // pixel handshake, so they are stable for the whole ISSUE..WAIT window
    assign bus.core_start_o    = core_start_q;
    assign bus.core_x0_o       = cx_q;
    assign bus.core_y0_o       = cy_q;
    assign bus.core_max_iter_o = max_iter_q;

    assign bus.pix_valid_o  = pix_valid_q;
    assign bus.pix_iter_o   = pix_iter_q;
    assign bus.pix_x_o      = px_q;
    assign bus.pix_y_o      = py_q;
    assign bus.pix_last_o   = pix_last_q;

    assign bus.busy_o       = busy_q;
    assign bus.frame_done_o = frame_done_q;
endmodule
